spi_lcd_rx: RTL and testbench
=============================

Name: spi_lcd_rx

Overview:
- Receiving end of the 4-wire LCD SPI link (cs_n, sclk, dc, mosi) that spi_lcd drives.
- Oversamples the link on the system clock and assembles bytes. Decodes the ST7735-style commands CASET (0x2A), RASET (0x2B) and RAMWR (0x2C).
- Emits addressed RGB565 pixel writes (x, y, data) for a framebuffer capture or display model.
- Sits on the far side of the LCD pins, either as an on-chip loopback/monitor or as the bench model.

Parameters:
- LCD_W, 132, panel width; reset value of the column window end is LCD_W-1.
- LCD_H, 162, panel height; reset value of the row window end is LCD_H-1.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- spi_cs_n  in  1  chip select, active low.
- spi_clk  in  1  SPI clock; mode 0; frequency must be ≤ clk/4.
- spi_dc  in  1  0 = command byte, 1 = data byte.
- spi_data  in  1  MOSI, MSB first.
- cmd_valid  out  1  one-cycle pulse per received command byte.
- cmd_byte  out  8  last command byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x  out  8  column of the pixel.
- pix_y  out  8  row of the pixel.
- pix_data  out  16  RGB565 pixel, first byte in bits [15:8].

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - cmd_valid=0, pix_valid=0, cmd_byte=0, pix_x=0, pix_y=0, pix_data=0.
  - Bit counter 0, FSM in IDLE.
  - Window xs=0, xe=LCD_W-1, ys=0, ye=LCD_H-1.
  - Synchronizer flops load idle levels: cs_n=1, sclk=0.
- Byte assembly:
  - Each SPI input passes through SYNC_STAGES flops.
  - A rising edge is detected as synchronized sclk changing 0→1 while synchronized cs_n=0.
  - mosi is shifted in on that edge. On the 8th bit, byte_done pulses with the byte and dc (dc sampled with bit 0).
  - cs_n high clears the bit counter; a partial byte is discarded.
- Latency: cmd_valid and pix_valid rise exactly SYNC_STAGES+2 clk cycles after the raw spi_clk rising edge carrying the final bit.
- FSM states: IDLE, CASET, RASET, RAMWR, SKIP.
  - Any command byte (dc=0): pulse cmd_valid and load cmd_byte. Then 0x2A→CASET, 0x2B→RASET, 0x2C→RAMWR, anything else→SKIP. The byte index is cleared.
  - A command byte aborts the current state immediately; a half pixel or partial window is dropped.
  - CASET/RASET take data bytes [start_hi, start_lo, end_hi, end_lo]. Only the lo bytes are used; hi bytes are ignored.
  - The window registers update only when the 4th byte arrives, then the FSM goes to IDLE. An incomplete sequence leaves the window unchanged.
  - Entering RAMWR sets x=xs, y=ys and clears the pixel byte phase.
- Pixel stream: in RAMWR, data bytes pair up (hi then lo). On the lo byte, pix_valid pulses with pix_x=x, pix_y=y, pix_data={hi,lo}.
- Address advance after each pixel:
  - If x==xe: x←xs, and y←(y==ye ? ys : y+1).
  - Otherwise x←x+1 mod 256.
  - Comparisons are equality only, so xs>xe wraps through 255.
- Data bytes in IDLE or SKIP are ignored.
- cs_n rising mid-pixel: the byte phase is kept, so cs toggling between bytes is legal (spi_lcd toggles cs per byte). Only the bit counter resets.
- Outputs pix_x, pix_y, pix_data and cmd_byte hold their values between pulses.

Optional Feature:
- Macro: SPI_LCD_RX_CLIP_EN.
- Defined: pix_valid is suppressed when x ≥ LCD_W or y ≥ LCD_H. Address advance is unchanged.
- Undefined: every completed pixel pulses pix_valid.

Decomposition:
- Shared package spi_lcd_pkg holds:
  - the command opcodes CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C;
  - the rx FSM state encoding;
  - the LCD_W/LCD_H defaults.
- One natural sub-module, spi_byte_rx: synchronizers, edge detect and shift register, producing byte_done, byte and dc. The decoder FSM and address logic stay in the top module.

Test Plan:
- Reset, then cmd 0x2C followed by data 0xF8,0x00 → one cmd_valid with cmd_byte=0x2C, one pix_valid with x=0, y=0, data=0xF800, at the stated latency.
- CASET 00,02,00,03; RASET 00,05,00,06; RAMWR followed by 5 pixels → (x,y) sequence (2,5),(3,5),(2,6),(3,6),(2,5).
- RAMWR, 3 data bytes, then cmd 0x2A → only 1 pix_valid; the dangling byte is dropped; cmd_valid fires for 0x2A.
- cs_n raised after 4 bits of a byte, then a full byte 0x2C → 0x2C decoded correctly; no spurious byte.
- CASET with only 2 data bytes, then RAMWR and 1 pixel → pixel at x=0, since the window is unchanged.
- With SPI_LCD_RX_CLIP_EN: CASET 00,82,00,84 (130..132), RAMWR, 3 pixels → pix_valid only for x=130 and 131; without the macro → 3 pulses.

Source files
------------

// File: rtl/spi_lcd_pkg.sv
// Shared definitions for the LCD SPI link: ST7735-style opcodes, panel defaults and rx FSM states.
package spi_lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned LCD_W_DEF = 132;
    localparam int unsigned LCD_H_DEF = 162;

    typedef enum logic [2:0] {
        StIdle,
        StCaset,
        StRaset,
        StRamwr,
        StSkip
    } rx_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: input synchronizers, sclk rise detect, MSB-first shifter.
module spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_dc,
    input  logic       spi_data,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       rx_dc
);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, dc_sync, data_sync;
    logic                   sclk_prev;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic                   dc_lat;
    logic                   cs_s, sclk_s, dc_s, data_s, rise;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev & ~cs_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            dc_sync   <= '0;
            data_sync <= '0;
            sclk_prev <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            dc_lat    <= 1'b0;
            byte_done <= 1'b0;
            rx_byte   <= 8'd0;
            rx_dc     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sclk_prev <= sclk_s;
            byte_done <= 1'b0;
            if (cs_s) begin
                // Deselect drops any partial byte.
                bit_cnt <= 3'd0;
            end else if (rise) begin
                shift   <= {shift[5:0], data_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd0) begin
                    dc_lat <= dc_s;
                end
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {shift, data_s};
                    rx_dc     <= dc_lat;
                end
            end
        end
    end

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD SPI receiver: decodes CASET/RASET/RAMWR and emits addressed RGB565 pixel writes.
// Define SPI_LCD_RX_CLIP_EN to suppress pixels falling outside the LCD_W x LCD_H panel.
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int unsigned LCD_W       = LCD_W_DEF,
    parameter int unsigned LCD_H       = LCD_H_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_clk,
    input  logic        spi_dc,
    input  logic        spi_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_data
);

    logic       byte_done, rx_dc;
    logic [7:0] rx_byte;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_byte_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_dc   (spi_dc),
        .spi_data (spi_data),
        .byte_done(byte_done),
        .rx_byte  (rx_byte),
        .rx_dc    (rx_dc)
    );

    rx_state_e  state;
    logic [1:0] idx;
    logic       phase;
    logic [7:0] hi_byte, start_lo;
    logic [7:0] xs, xe, ys, ye, x, y;
    logic       in_bounds;

`ifdef SPI_LCD_RX_CLIP_EN
    assign in_bounds = ({1'b0, x} < 9'(LCD_W)) && ({1'b0, y} < 9'(LCD_H));
`else
    assign in_bounds = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            idx       <= 2'd0;
            phase     <= 1'b0;
            hi_byte   <= 8'd0;
            start_lo  <= 8'd0;
            xs        <= 8'd0;
            xe        <= 8'(LCD_W - 1);
            ys        <= 8'd0;
            ye        <= 8'(LCD_H - 1);
            x         <= 8'd0;
            y         <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'd0;
            pix_valid <= 1'b0;
            pix_x     <= 8'd0;
            pix_y     <= 8'd0;
            pix_data  <= 16'd0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (byte_done && !rx_dc) begin
                // A command always wins, discarding any half pixel or partial window.
                cmd_valid <= 1'b1;
                cmd_byte  <= rx_byte;
                idx       <= 2'd0;
                phase     <= 1'b0;
                case (rx_byte)
                    CMD_CASET: state <= StCaset;
                    CMD_RASET: state <= StRaset;
                    CMD_RAMWR: begin
                        state <= StRamwr;
                        x     <= xs;
                        y     <= ys;
                    end
                    default:   state <= StSkip;
                endcase
            end else if (byte_done) begin
                case (state)
                    StCaset, StRaset: begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd1) begin
                            start_lo <= rx_byte;
                        end
                        if (idx == 2'd3) begin
                            if (state == StCaset) begin
                                xs <= start_lo;
                                xe <= rx_byte;
                            end else begin
                                ys <= start_lo;
                                ye <= rx_byte;
                            end
                            state <= StIdle;
                        end
                    end
                    StRamwr: begin
                        if (!phase) begin
                            hi_byte <= rx_byte;
                            phase   <= 1'b1;
                        end else begin
                            phase     <= 1'b0;
                            pix_valid <= in_bounds;
                            pix_x     <= x;
                            pix_y     <= y;
                            pix_data  <= {hi_byte, rx_byte};
                            // Equality-only compares let a window with xs > xe wrap through 255.
                            if (x == xe) begin
                                x <= xs;
                                y <= (y == ye) ? ys : y + 8'd1;
                            end else begin
                                x <= x + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: bit-banged SPI bytes, pulse logging and hand-computed expectations.
module tb_spi_lcd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_dc = 1'b0;
    logic        spi_data = 1'b0;
    logic        cmd_valid, pix_valid;
    logic [7:0]  cmd_byte, pix_x, pix_y;
    logic [15:0] pix_data;

    int total = 0;
    int bad = 0;

    int          cmd_cnt = 0;
    int          pix_cnt = 0;
    logic [7:0]  cmd_log [64];
    logic [7:0]  px_log [64];
    logic [7:0]  py_log [64];
    logic [15:0] pd_log [64];

    spi_lcd_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_dc   (spi_dc),
        .spi_data (spi_data),
        .cmd_valid(cmd_valid),
        .cmd_byte (cmd_byte),
        .pix_valid(pix_valid),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_data (pix_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_log[cmd_cnt % 64] <= cmd_byte;
            cmd_cnt <= cmd_cnt + 1;
        end
        if (pix_valid) begin
            px_log[pix_cnt % 64] <= pix_x;
            py_log[pix_cnt % 64] <= pix_y;
            pd_log[pix_cnt % 64] <= pix_data;
            pix_cnt <= pix_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_dc   = 1'b0;
        spi_data = 1'b0;
        rst_n    = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // lat: 0 = no latency probe, 1 = probe cmd_valid, 2 = probe pix_valid on the last bit.
    task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits, input int lat);
        @(posedge clk);
        #1 spi_cs_n = 1'b0;
        spi_dc = dc;
        repeat (3) @(posedge clk);
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(posedge clk);
            #1 spi_data = b[i];
            repeat (3) @(posedge clk);
            #1 spi_clk = 1'b1;
            if (i == 0 && lat != 0) begin
                repeat (3) @(posedge clk);
                #1 check_eq("lat_early", (lat == 1) ? cmd_valid : pix_valid, 1'b0);
                @(posedge clk);
                #1 check_eq("lat_exact", (lat == 1) ? cmd_valid : pix_valid, 1'b1);
            end else begin
                repeat (4) @(posedge clk);
            end
            #1 spi_clk = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8, 0);
    endtask

    task automatic send_pix(input logic [15:0] d);
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
    endtask

    task automatic check_pix(input int n, input logic [7:0] ex, input logic [7:0] ey,
                             input logic [15:0] ed);
        check_eq($sformatf("pix%0d_x", n), px_log[n % 64], ex);
        check_eq($sformatf("pix%0d_y", n), py_log[n % 64], ey);
        check_eq($sformatf("pix%0d_d", n), pd_log[n % 64], ed);
    endtask

    initial begin
        int cb, pb;
        logic [7:0] exp_x [5];
        logic [7:0] exp_y [5];

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_pix_valid", pix_valid, 0);
        check_eq("rst_cmd_byte", cmd_byte, 0);
        check_eq("rst_pix_x", pix_x, 0);
        check_eq("rst_pix_y", pix_y, 0);
        check_eq("rst_pix_data", pix_data, 0);
        do_reset();

        // RAMWR at reset window, one pixel, with latency probes
        send_bits(1'b0, 8'h2C, 8, 1);
        send_byte(1'b1, 8'hF8);
        send_bits(1'b1, 8'h00, 8, 2);
        check_eq("t1_cmd_cnt", cmd_cnt, 1);
        check_eq("t1_cmd_byte", cmd_log[0], 8'h2C);
        check_eq("t1_pix_cnt", pix_cnt, 1);
        check_pix(0, 8'd0, 8'd0, 16'hF800);

        // 2x2 window walk with wrap back to the start
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        pb = pix_cnt;
        exp_x = '{8'd2, 8'd3, 8'd2, 8'd3, 8'd2};
        exp_y = '{8'd5, 8'd5, 8'd6, 8'd6, 8'd5};
        for (int i = 0; i < 5; i++) send_pix(16'h1230 + 16'(i));
        check_eq("t2_pix_cnt", pix_cnt - pb, 5);
        for (int i = 0; i < 5; i++) check_pix(pb + i, exp_x[i], exp_y[i], 16'h1230 + 16'(i));

        // Command mid-pixel drops the dangling byte
        cb = cmd_cnt;
        pb = pix_cnt;
        send_byte(1'b0, 8'h2C);
        send_pix(16'hBEEF);
        send_byte(1'b1, 8'h77);
        send_byte(1'b0, 8'h2A);
        check_eq("t3_pix_cnt", pix_cnt - pb, 1);
        check_pix(pb, 8'd2, 8'd5, 16'hBEEF);
        check_eq("t3_cmd_cnt", cmd_cnt - cb, 2);
        check_eq("t3_cmd_last", cmd_log[(cmd_cnt - 1) % 64], 8'h2A);
        pb = pix_cnt;
        send_byte(1'b0, 8'h2C);
        send_pix(16'hABCD);
        check_eq("t3b_pix_cnt", pix_cnt - pb, 1);
        check_pix(pb, 8'd2, 8'd5, 16'hABCD);

        // Partial byte discarded on deselect
        cb = cmd_cnt;
        send_bits(1'b0, 8'hF0, 4, 0);
        send_byte(1'b0, 8'h2C);
        check_eq("t4_cmd_cnt", cmd_cnt - cb, 1);
        check_eq("t4_cmd_byte", cmd_log[cb % 64], 8'h2C);

        // Incomplete CASET leaves the reset window
        do_reset();
        pb = pix_cnt;
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b0, 8'h2C);
        send_pix(16'h0F0F);
        check_eq("t5_pix_cnt", pix_cnt - pb, 1);
        check_pix(pb, 8'd0, 8'd0, 16'h0F0F);

        // Window straddling the panel edge: 130..132
        pb = pix_cnt;
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h82);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h84);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 3; i++) send_pix(16'h5500 + 16'(i));
`ifdef SPI_LCD_RX_CLIP_EN
        check_eq("t6_pix_cnt", pix_cnt - pb, 2);
`else
        check_eq("t6_pix_cnt", pix_cnt - pb, 3);
        check_pix(pb + 2, 8'd132, 8'd0, 16'h5502);
`endif
        check_pix(pb, 8'd130, 8'd0, 16'h5500);
        check_pix(pb + 1, 8'd131, 8'd0, 16'h5501);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
